// File: rtl/cpu_pkg.sv
// Shared types and constants for the control unit and its instruction decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, instruction class enum, opcode constants, IR field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LDI  = 3'd1,
        CLS_JMP  = 3'd2,
        CLS_BR   = 3'd3,
        CLS_HALT = 3'd4
    } instr_class_t;

    // Opcodes 0x0..OP_ALU_MAX are passed straight through to the ALU.
    localparam logic [3:0] OP_ALU_MAX = 4'hB;
    localparam logic [3:0] OP_LDI     = 4'hC;
    localparam logic [3:0] OP_JMP     = 4'hD;
    localparam logic [3:0] OP_BR      = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    // Instruction word field positions.
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int RA_MSB     = 7;
    localparam int RA_LSB     = 4;
    localparam int RB_MSB     = 3;
    localparam int RB_LSB     = 0;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;
    localparam int BR_SEL_BIT = 11;  // BR condition select: 0 = zero flag, 1 = carry flag

    function automatic instr_class_t op_class(input logic [3:0] op);
        instr_class_t cls;
        cls = CLS_ALU;
        if (op > OP_ALU_MAX) begin
            case (op)
                OP_LDI:  cls = CLS_LDI;
                OP_JMP:  cls = CLS_JMP;
                OP_BR:   cls = CLS_BR;
                default: cls = CLS_HALT;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into control fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow ir continuously.
// Ports: ir in; cls, op, rd, ra, rb, imm, br_on_carry, wr_intent, alu_intent out.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0]  ir,
    output instr_class_t cls,
    output logic [3:0]   op,
    output logic [3:0]   rd,
    output logic [3:0]   ra,
    output logic [3:0]   rb,
    output logic [7:0]   imm,
    output logic         br_on_carry,
    output logic         wr_intent,
    output logic         alu_intent
);

    assign op          = ir[OP_MSB:OP_LSB];
    assign rd          = ir[RD_MSB:RD_LSB];
    assign ra          = ir[RA_MSB:RA_LSB];
    assign rb          = ir[RB_MSB:RB_LSB];
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign br_on_carry = ir[BR_SEL_BIT];
    assign cls         = op_class(op);

    // Only ALU ops and LDI write the register file; only ALU ops select the ALU result.
    assign wr_intent   = (cls == CLS_ALU) || (cls == CLS_LDI);
    assign alu_intent  = (cls == CLS_ALU);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: HALTED -> FETCH -> EXEC sequencing, PC, IR and ALU flags.
// Latency: 2 cycles minimum per instruction (FETCH with same-cycle ack, then one EXEC cycle).
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_ack; start ignored unless HALTED.
// Ports: clk, rst, start; imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//        alu_en, alu_opcode, user_write_data, write_addr, ra_addr, rb_addr, write_en to datapath;
//        alu_zero, alu_carry flags from datapath; halted status.
module control_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(8'h00)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            alu_en,
    output logic [3:0]      alu_opcode,
    output logic [7:0]      user_write_data,
    output logic [3:0]      write_addr,
    output logic [3:0]      ra_addr,
    output logic [3:0]      rb_addr,
    output logic            write_en,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            halted
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            zf;
    logic            cf;

    instr_class_t    cls;
    logic [3:0]      op;
    logic [3:0]      rd;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [7:0]      imm;
    logic            br_on_carry;
    logic            wr_intent;
    logic            alu_intent;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_pc;
    logic            br_taken;

    instr_decode u_decode (
        .ir          (ir),
        .cls         (cls),
        .op          (op),
        .rd          (rd),
        .ra          (ra),
        .rb          (rb),
        .imm         (imm),
        .br_on_carry (br_on_carry),
        .wr_intent   (wr_intent),
        .alu_intent  (alu_intent)
    );

    assign pc_inc   = pc + PC_W'(1);
    assign imm_pc   = PC_W'(imm);
    // zf/cf only change at the end of an ALU EXEC, so a BR sees the flags of the
    // most recent earlier ALU op.
    assign br_taken = br_on_carry ? cf : zf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HALTED;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            zf    <= 1'b0;
            cf    <= 1'b0;
        end else begin
            case (state)
                ST_HALTED: begin
                    if (start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (cls)
                        CLS_ALU: begin
                            zf <= alu_zero;
                            cf <= alu_carry;
                            pc <= pc_inc;
                        end
                        CLS_LDI:  pc <= pc_inc;
                        CLS_JMP:  pc <= imm_pc;
                        CLS_BR:   pc <= br_taken ? imm_pc : pc_inc;
                        CLS_HALT: begin
                            pc    <= pc_inc;
                            state <= ST_HALTED;
                        end
                        default:  pc <= pc_inc;
                    endcase
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

    // Outputs depend only on registered state, so the async reset clears them immediately.
    assign halted          = (state == ST_HALTED);
    assign imem_req        = (state == ST_FETCH);
    assign imem_addr       = pc;
    assign write_en        = (state == ST_EXEC) && wr_intent;
    assign alu_en          = (state == ST_EXEC) && alu_intent;
    assign alu_opcode      = op;
    assign write_addr      = rd;
    assign ra_addr         = ra;
    assign rb_addr         = rb;
    assign user_write_data = imm;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PC_W, default 8, width of program counter and instruction-memory address.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  pulse; leaves HALTED and begins fetching at current PC.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_W  fetch address (current PC).
REQ-008 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  input  16  instruction word.
REQ-010 alu_en  output  1  selects ALU result as datapath write data.
REQ-011 alu_opcode  output  4  ALU operation.
REQ-012 user_write_data  output  8  immediate write data.
REQ-013 write_addr, ra_addr, rb_addr  output  4 each  register addresses.
REQ-014 write_en  output  1  register-file write strobe.
REQ-015 alu_zero, alu_carry  input  1 each  ALU flags from datapath.
REQ-016 halted  output  1  high in HALTED state.

Function
REQ-017 Encoding: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8=[7:0].
REQ-018 op 0x0-0xB: ALU op; alu_opcode=op, ra_addr=ra, rb_addr=rb, write_addr=rd, alu_en=1.
REQ-019 op 0xC LDI: write_addr=rd, user_write_data=imm8, alu_en=0.
REQ-020 op 0xD JMP: PC<=imm8, no register write.
REQ-021 op 0xE BR: bit[11]=0 tests zf, bit[11]=1 tests cf; taken -> PC<=imm8, else PC<=PC+1; no write.
REQ-022 op 0xF HALT: PC<=PC+1, enter HALTED.
REQ-023 States HALTED, FETCH, EXEC; reset state HALTED.
REQ-024 HALTED: start=1 -> FETCH next cycle; imem_ack ignored.
REQ-025 FETCH: imem_req=1, imem_addr=PC held stable until imem_ack; on ack latch imem_rdata into IR, go EXEC.
REQ-026 EXEC lasts exactly one cycle; write_en=1 only in EXEC and only for ALU/LDI; then FETCH (or HALTED for HALT).
REQ-027 Non-branch, non-HALT instructions: PC<=PC+1 at end of EXEC; PC wraps 0xFF->0x00.
REQ-028 zf/cf registered from alu_zero/alu_carry at end of EXEC of ALU ops only; LDI/JMP/BR/HALT preserve them.
REQ-029 BR in EXEC uses zf/cf values from before this EXEC cycle.
REQ-030 Outside EXEC: write_en=0, alu_en=0; address/data outputs decoded from IR continuously.
REQ-031 Minimum instruction time 2 cycles (FETCH with same-cycle ack, EXEC).
REQ-032 start asserted outside HALTED is ignored.

Reset
REQ-033 rst=1 immediately forces state=HALTED, PC=RESET_PC, IR=16'h0000, zf=cf=0, imem_req=0, write_en=0, alu_en=0, halted=1.
REQ-034 rst mid-FETCH abandons the request; a late imem_ack after reset is ignored.
REQ-035 After rst deasserts, control_unit remains HALTED until start.

Structure
REQ-036 Shared package cpu_pkg holds state enum, opcode constants (OP_LDI=0xC, OP_JMP=0xD, OP_BR=0xE, OP_HALT=0xF), field positions.
REQ-037 One combinational sub-module instr_decode maps IR to control fields (class, addresses, imm, write-enable intent).

Verification
REQ-038 Reset, start, imem always ack, program LDI r1,0x05; LDI r2,0x03; op0 r3,r1,r2; HALT -> write_en pulses at writes to r1=0x05, r2=0x03, r3 with alu_en=1, alu_opcode=0; halted=1, PC=0x04.
REQ-039 imem_ack delayed 3 cycles -> imem_req and imem_addr stable 4 cycles; exactly one EXEC and one write_en.
REQ-040 ALU op giving alu_zero=1, then LDI, then BR bit11=0 imm=0x20 -> branch taken, next imem_addr=0x20.
REQ-041 BR with cf=0 at PC=0x10 -> next imem_addr=0x11; JMP 0xFF then LDI at 0xFF -> next fetch at 0x00.
REQ-042 rst asserted while imem_req=1 -> imem_req low same cycle, halted=1, late ack causes no write.
REQ-043 start pulsed during FETCH -> no effect on sequence.
